dmem_responder: RTL and testbench

Data-memory responder for the pipeline's data port. It sits on the far side of the MEM stage's `dmem_*` request interface and accepts word-aligned read and write requests expressed as byte masks. It services each request from an internal word array after a fixed, parameterised latency and returns a single-cycle `dmem_resp` with read data. It is used as the backing data memory in pipeline simulation and as the reference responder for the stall logic.

---
 rtl/dmem_responder.sv | 150 +++++++++++++++
 tb/tb_dmem_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data-memory responder with byte-masked reads and writes
// One request in flight; request fields are latched on acceptance, so inputs are ignored while busy.
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] dmem_addr,
   input  logic [3:0]  dmem_rmask,
   input  logic [3:0]  dmem_wmask,
   input  logic [31:0] dmem_wdata,
   output logic [31:0] dmem_rdata,
   output logic        dmem_resp,
   output logic [31:0] rd_count,
   output logic [31:0] wr_count
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [3:0]    rmask_q, rmask_d;
   logic [3:0]    wmask_q, wmask_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          resp_q, resp_d;
   logic [31:0]   rd_count_q, rd_count_d;
   logic [31:0]   wr_count_q, wr_count_d;

   logic [31:0]   mem [DEPTH_WORDS];

   logic          req_present;
   logic          accept;
   logic          perform;
   logic [AW-1:0] acc_addr;
   logic [3:0]    acc_rmask;
   logic [3:0]    acc_wmask;
   logic [31:0]   acc_wdata;
   logic [31:0]   old_word;
   logic          unused_addr_bits;

   assign unused_addr_bits = ^{dmem_addr[31:2+AW], dmem_addr[1:0]};

   always_comb begin
      req_present = |(dmem_rmask | dmem_wmask);
      accept      = req_present && (state_q != S_BUSY);

      // With LATENCY=1 the access uses the live inputs on the accept edge.
      if (state_q == S_BUSY) begin
         acc_addr  = addr_q;
         acc_rmask = rmask_q;
         acc_wmask = wmask_q;
         acc_wdata = wdata_q;
      end else begin
         acc_addr  = dmem_addr[2 +: AW];
         acc_rmask = dmem_rmask;
         acc_wmask = dmem_wmask;
         acc_wdata = dmem_wdata;
      end

      perform = !rst && (((state_q == S_BUSY) && (cnt_q == CW'(1))) ||
                         ((LATENCY == 1) && accept));
      old_word = mem[acc_addr];

      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      rmask_d = rmask_q;
      wmask_d = wmask_q;
      wdata_d = wdata_q;

      case (state_q)
         S_BUSY: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = S_RESP;
         end
         default: begin
            if (accept) begin
               addr_d  = dmem_addr[2 +: AW];
               rmask_d = dmem_rmask;
               wmask_d = dmem_wmask;
               wdata_d = dmem_wdata;
               if (LATENCY == 1) begin
                  state_d = S_RESP;
               end else begin
                  cnt_d   = CW'(LATENCY - 1);
                  state_d = S_BUSY;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
      endcase

      resp_d  = perform;
      rdata_d = 32'h0;
      if (perform) begin
         for (int i = 0; i < 4; i++) begin
            if (acc_rmask[i]) rdata_d[8*i +: 8] = old_word[8*i +: 8];
         end
      end
      rd_count_d = rd_count_q + ((perform && (acc_rmask != 4'h0)) ? 32'd1 : 32'd0);
      wr_count_d = wr_count_q + ((perform && (acc_wmask != 4'h0)) ? 32'd1 : 32'd0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         rmask_q    <= '0;
         wmask_q    <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         resp_q     <= 1'b0;
         rd_count_q <= '0;
         wr_count_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         rmask_q    <= rmask_d;
         wmask_q    <= wmask_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         resp_q     <= resp_d;
         rd_count_q <= rd_count_d;
         wr_count_q <= wr_count_d;
      end
   end

   // Array is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (perform) begin
         for (int i = 0; i < 4; i++) begin
            if (acc_wmask[i]) mem[acc_addr][8*i +: 8] <= acc_wdata[8*i +: 8];
         end
      end
   end

   assign dmem_rdata = rdata_q;
   assign dmem_resp  = resp_q;
   assign rd_count   = rd_count_q;
   assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed and randomized checks of dmem_responder at LATENCY 1, 2 and 4
// Three instances share clk/rst; a word-array model per instance predicts read data and counters.
module tb_dmem_responder;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] addr_i  [3];
   logic [3:0]  rm_i    [3];
   logic [3:0]  wm_i    [3];
   logic [31:0] wdata_i [3];
   logic [31:0] rdata_o [3];
   logic        resp_o  [3];
   logic [31:0] rdc_o   [3];
   logic [31:0] wrc_o   [3];

   int          ntests = 0;
   int          nfail  = 0;
   int          lat_of [3] = '{1, 2, 4};
   logic [31:0] mm     [3][1024];
   int          exp_rd [3];
   int          exp_wr [3];
   logic [31:0] rd;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_l1 (
      .clk(clk), .rst(rst), .dmem_addr(addr_i[0]), .dmem_rmask(rm_i[0]), .dmem_wmask(wm_i[0]),
      .dmem_wdata(wdata_i[0]), .dmem_rdata(rdata_o[0]), .dmem_resp(resp_o[0]),
      .rd_count(rdc_o[0]), .wr_count(wrc_o[0]));
   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_l2 (
      .clk(clk), .rst(rst), .dmem_addr(addr_i[1]), .dmem_rmask(rm_i[1]), .dmem_wmask(wm_i[1]),
      .dmem_wdata(wdata_i[1]), .dmem_rdata(rdata_o[1]), .dmem_resp(resp_o[1]),
      .rd_count(rdc_o[1]), .wr_count(wrc_o[1]));
   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) u_l4 (
      .clk(clk), .rst(rst), .dmem_addr(addr_i[2]), .dmem_rmask(rm_i[2]), .dmem_wmask(wm_i[2]),
      .dmem_wdata(wdata_i[2]), .dmem_rdata(rdata_o[2]), .dmem_resp(resp_o[2]),
      .rd_count(rdc_o[2]), .wr_count(wrc_o[2]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One request on instance k; returns in its response cycle with inputs still held.
   task automatic xact(input int k, input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                       input logic [31:0] wd, input bit scramble, output logic [31:0] rdv);
      logic [31:0] exp_data;
      int          idx;
      int          lat;
      idx      = int'(a[11:2]);
      exp_data = 32'h0;
      for (int i = 0; i < 4; i++) begin
         if (rm[i]) exp_data[8*i +: 8] = mm[k][idx][8*i +: 8];
      end
      for (int i = 0; i < 4; i++) begin
         if (wm[i]) mm[k][idx][8*i +: 8] = wd[8*i +: 8];
      end
      if (rm != 4'h0) exp_rd[k]++;
      if (wm != 4'h0) exp_wr[k]++;

      addr_i[k] = a; rm_i[k] = rm; wm_i[k] = wm; wdata_i[k] = wd;
      lat = -1;
      rdv = 32'hxxxxxxxx;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (resp_o[k]) begin
            lat = n;
            rdv = rdata_o[k];
            break;
         end
         if (scramble) begin
            addr_i[k]  = 32'h800 + ($urandom_range(0, 63) << 2);
            wdata_i[k] = $urandom;
         end
      end
      check($sformatf("latency[%0d]", k), lat, lat_of[k]);
      check($sformatf("rdata[%0d] a=%h", k, a), rdv, exp_data);
   endtask

   task automatic idle(input int k, input int n);
      rm_i[k] = 4'h0; wm_i[k] = 4'h0;
      @(posedge clk); #1;
      check($sformatf("idle_resp[%0d]", k), {31'h0, resp_o[k]}, 32'h0);
      check($sformatf("idle_rdata[%0d]", k), rdata_o[k], 32'h0);
      repeat (n - 1) begin @(posedge clk); #1; end
   endtask

   task automatic check_counts(input int k);
      check($sformatf("rd_count[%0d]", k), rdc_o[k], exp_rd[k]);
      check($sformatf("wr_count[%0d]", k), wrc_o[k], exp_wr[k]);
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         addr_i[k] = '0; rm_i[k] = '0; wm_i[k] = '0; wdata_i[k] = '0;
         exp_rd[k] = 0; exp_wr[k] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rst_resp[%0d]", k), {31'h0, resp_o[k]}, 32'h0);
         check($sformatf("rst_rdata[%0d]", k), rdata_o[k], 32'h0);
         check_counts(k);
      end
      rst = 1'b0;

      // Reset mid-BUSY on the LATENCY=4 instance drops the pending write.
      xact(2, 32'h200, 4'h0, 4'hF, 32'h55AA55AA, 1'b0, rd);
      idle(2, 1);
      addr_i[2] = 32'h200; wm_i[2] = 4'hF; wdata_i[2] = 32'hFFFFFFFF;
      @(posedge clk); #1;
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      check("rstmid_resp", {31'h0, resp_o[2]}, 32'h0);
      check("rstmid_rdata", rdata_o[2], 32'h0);
      for (int k = 0; k < 3; k++) begin
         exp_rd[k] = 0; exp_wr[k] = 0;
      end
      check_counts(2);
      wm_i[2] = 4'h0;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         check("rstmid_quiet", {31'h0, resp_o[2]}, 32'h0);
      end
      xact(2, 32'h200, 4'hF, 4'h0, 32'h0, 1'b0, rd);
      check("rstmid_word", rd, 32'h55AA55AA);
      idle(2, 1);

      // LATENCY=2: write then back-to-back read, byte lanes, simultaneous read/write.
      xact(1, 32'h40, 4'h0, 4'hF, 32'hDEADBEEF, 1'b0, rd);
      xact(1, 32'h40, 4'hF, 4'h0, 32'h0, 1'b0, rd);
      check("wr_rd", rd, 32'hDEADBEEF);
      idle(1, 1);
      check_counts(1);
      xact(1, 32'h40, 4'h0, 4'b0100, 32'h00AB0000, 1'b0, rd);
      idle(1, 1);
      xact(1, 32'h40, 4'hF, 4'h0, 32'h0, 1'b0, rd);
      check("lanes_full", rd, 32'hDEABBEEF);
      xact(1, 32'h40, 4'b0011, 4'h0, 32'h0, 1'b0, rd);
      check("lanes_low", rd, 32'h0000BEEF);
      idle(1, 2);
      xact(1, 32'h80, 4'h0, 4'hF, 32'h12345678, 1'b0, rd);
      idle(1, 1);
      xact(1, 32'h80, 4'hF, 4'hF, 32'hCAFEF00D, 1'b0, rd);
      check("rw_old", rd, 32'h12345678);
      xact(1, 32'h80, 4'hF, 4'h0, 32'h0, 1'b0, rd);
      check("rw_new", rd, 32'hCAFEF00D);
      idle(1, 1);
      check_counts(1);

      // LATENCY=1: back-to-back with address wrap (0x1000 aliases word 0).
      xact(0, 32'h1000, 4'h0, 4'hF, 32'h11111111, 1'b0, rd);
      xact(0, 32'h0, 4'hF, 4'h0, 32'h0, 1'b0, rd);
      check("wrap", rd, 32'h11111111);
      idle(0, 1);
      check_counts(0);

      // LATENCY=4: inputs scrambled while busy must not disturb the latched write.
      xact(2, 32'h300, 4'h0, 4'hF, 32'hA5A5A5A5, 1'b1, rd);
      idle(2, 1);
      xact(2, 32'h300, 4'hF, 4'h0, 32'h0, 1'b0, rd);
      check("stable", rd, 32'hA5A5A5A5);
      idle(2, 1);

      // Randomized traffic over a small pre-initialised window, with aliasing high address bits.
      for (int k = 0; k < 3; k++) begin
         for (int w = 0; w < 8; w++) begin
            xact(k, 32'h100 + w * 4, 4'h0, 4'hF, $urandom, 1'b0, rd);
         end
         for (int t = 0; t < 30; t++) begin
            logic [31:0] a;
            logic [3:0]  rm;
            logic [3:0]  wm;
            a  = 32'h100 | ($urandom_range(0, 7) << 2) | ($urandom_range(0, 3) << 12) | $urandom_range(0, 3);
            rm = 4'($urandom_range(0, 15));
            wm = 4'($urandom_range(0, 15));
            if ((rm | wm) == 4'h0) rm = 4'hF;
            xact(k, a, rm, wm, $urandom, 1'($urandom_range(0, 1)), rd);
            if ($urandom_range(0, 2) == 0) idle(k, 1);
         end
         idle(k, 1);
         check_counts(k);
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
